addsub16_arbiter: RTL and testbench

- Shares one 16-bit add/subtract datapath between two requesters.
- Datapath: XOR-bank operand inverter plus adder with carry-in.
- The block arbitrates round-robin, captures the winning operands, sequences one operation through the datapath, and returns a registered result with flags to the granted requester over a valid/ready handshake.
- Sits between the instruction-side users of the add/sub unit and the unit itself; one operation outstanding at a time.

---
 rtl/addsub_pkg.sv | 16 +
 rtl/addsub16_core.sv | 36 +++
 rtl/addsub16_arbiter.sv | 118 +++++++++++
 tb/tb_addsub16_arbiter.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/addsub_pkg.sv
`default_nettype none
// ============================================================================
// Module      : addsub_pkg
// Description : Shared constants for the add/sub arbiter slice.
// Revision    : 1.0 - initial release
// ============================================================================
package addsub_pkg;

    localparam int C_WIDTH = 16;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_EXEC = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;

endpackage : addsub_pkg
`default_nettype wire

// File: rtl/addsub16_core.sv
`default_nettype none
// ============================================================================
// Module      : addsub16_core
// Description : Combinational add/subtract: XOR-bank inverter plus adder.
// Revision    : 1.0 - initial release
// ============================================================================
module addsub16_core
    import addsub_pkg::*;
#(
    parameter int WIDTH = C_WIDTH
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    output logic [WIDTH-1:0] y,
    output logic             carry,
    output logic             ovf
);

    logic [WIDTH-1:0] w_bx;
    logic [WIDTH:0]   w_sum;

    generate
        for (genvar i = 0; i < WIDTH; i++) begin : g_xor
            assign w_bx[i] = b[i] ^ sub;
        end
    endgenerate

    // Subtraction is two's complement: invert B and feed sub in as carry-in.
    assign w_sum = {1'b0, a} + {1'b0, w_bx} + {{WIDTH{1'b0}}, sub};
    assign y     = w_sum[WIDTH-1:0];
    assign carry = w_sum[WIDTH];
    assign ovf   = (a[WIDTH-1] == w_bx[WIDTH-1]) && (w_sum[WIDTH-1] != a[WIDTH-1]);

endmodule : addsub16_core
`default_nettype wire

// File: rtl/addsub16_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : addsub16_arbiter
// Description : Round-robin arbiter sharing one add/sub datapath between two
//               requesters, with a registered valid/ready response.
// Revision    : 1.0 - initial release
// ============================================================================
module addsub16_arbiter
    import addsub_pkg::*;
#(
    parameter int WIDTH   = C_WIDTH,
    parameter bit RR_INIT = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [1:0]       req_valid,
    output logic [1:0]       req_ready,
    input  logic [WIDTH-1:0] a0,
    input  logic [WIDTH-1:0] b0,
    input  logic             sub0,
    input  logic [WIDTH-1:0] a1,
    input  logic [WIDTH-1:0] b1,
    input  logic             sub1,
    output logic             rsp_valid,
    output logic             rsp_id,
    output logic [WIDTH-1:0] rsp_data,
    output logic             rsp_carry,
    output logic             rsp_ovf,
    output logic             rsp_zero,
    input  logic             rsp_ready
);

    logic [1:0]       r_state;
    logic [1:0]       w_state_nxt;
    logic             r_rr_ptr;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic             r_sub;
    logic             r_id;
    logic             w_grant;
    logic             w_grant_id;
    logic [WIDTH-1:0] w_y;
    logic             w_carry;
    logic             w_ovf;

    addsub16_core #(
        .WIDTH (WIDTH)
    ) u_core (
        .a     (r_a),
        .b     (r_b),
        .sub   (r_sub),
        .y     (w_y),
        .carry (w_carry),
        .ovf   (w_ovf)
    );

    always_comb begin
        w_state_nxt = r_state;
        w_grant     = 1'b0;
        w_grant_id  = 1'b0;
        req_ready   = 2'b00;
        case (r_state)
            ST_IDLE: begin
                // The priority pointer only matters when both requesters contend.
                case (req_valid)
                    2'b01:   begin w_grant = 1'b1; w_grant_id = 1'b0;     end
                    2'b10:   begin w_grant = 1'b1; w_grant_id = 1'b1;     end
                    2'b11:   begin w_grant = 1'b1; w_grant_id = r_rr_ptr; end
                    default: begin w_grant = 1'b0; w_grant_id = 1'b0;     end
                endcase
                if (w_grant) begin
                    req_ready   = w_grant_id ? 2'b10 : 2'b01;
                    w_state_nxt = ST_EXEC;
                end
            end
            ST_EXEC: w_state_nxt = ST_RESP;
            ST_RESP: if (rsp_ready) w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_rr_ptr  <= RR_INIT;
            r_a       <= '0;
            r_b       <= '0;
            r_sub     <= 1'b0;
            r_id      <= 1'b0;
            rsp_data  <= '0;
            rsp_carry <= 1'b0;
            rsp_ovf   <= 1'b0;
            rsp_zero  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (w_grant) begin
                r_a   <= w_grant_id ? a1   : a0;
                r_b   <= w_grant_id ? b1   : b0;
                r_sub <= w_grant_id ? sub1 : sub0;
                r_id  <= w_grant_id;
            end
            if (r_state == ST_EXEC) begin
                rsp_data  <= w_y;
                rsp_carry <= w_carry;
                rsp_ovf   <= w_ovf;
                rsp_zero  <= (w_y == '0);
            end
            if ((r_state == ST_RESP) && rsp_ready) begin
                r_rr_ptr <= ~r_id;
            end
        end
    end

    assign rsp_valid = (r_state == ST_RESP);
    assign rsp_id    = r_id;

endmodule : addsub16_arbiter
`default_nettype wire

// File: tb/tb_addsub16_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_addsub16_arbiter
// Description : Directed, table-driven self-checking bench for addsub16_arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_addsub16_arbiter;

    logic        clk;
    logic        rst;
    logic [1:0]  req_valid;
    logic [1:0]  req_ready;
    logic [15:0] a0, b0, a1, b1;
    logic        sub0, sub1;
    logic        rsp_valid, rsp_id, rsp_carry, rsp_ovf, rsp_zero, rsp_ready;
    logic [15:0] rsp_data;

    int n_cmp = 0;
    int n_err = 0;

    typedef struct {
        logic        id;
        logic [15:0] a;
        logic [15:0] b;
        logic        sub;
        logic [15:0] y;
        logic        c;
        logic        o;
        logic        z;
    } vec_t;

    vec_t vecs[8];

    addsub16_arbiter #(
        .WIDTH   (16),
        .RR_INIT (1'b0)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .a0        (a0),
        .b0        (b0),
        .sub0      (sub0),
        .a1        (a1),
        .b1        (b1),
        .sub1      (sub1),
        .rsp_valid (rsp_valid),
        .rsp_id    (rsp_id),
        .rsp_data  (rsp_data),
        .rsp_carry (rsp_carry),
        .rsp_ovf   (rsp_ovf),
        .rsp_zero  (rsp_zero),
        .rsp_ready (rsp_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // {id, data, carry, ovf, zero} packed for compact comparison
    function automatic logic [19:0] rsp_pack(input logic id, input logic [15:0] y,
                                             input logic c, input logic o, input logic z);
        return {id, y, c, o, z};
    endfunction

    // Issue one operation from an idle DUT; called just after a negedge.
    task automatic run_op(input vec_t v, input string name);
        int k;
        if (v.id) begin a1 = v.a; b1 = v.b; sub1 = v.sub; req_valid = 2'b10; end
        else      begin a0 = v.a; b0 = v.b; sub0 = v.sub; req_valid = 2'b01; end
        #1;
        k = 0;
        while (req_ready == 2'b00 && k < 8) begin
            @(negedge clk); #1; k++;
        end
        chk({name, "_ready"}, 64'(req_ready), v.id ? 64'h2 : 64'h1);
        @(negedge clk);
        req_valid = 2'b00;
        #1;
        chk({name, "_exec_nvalid"}, 64'(rsp_valid), 64'h0);
        @(negedge clk); #1;
        chk({name, "_valid"}, 64'(rsp_valid), 64'h1);
        chk({name, "_rsp"}, 64'(rsp_pack(rsp_id, rsp_data, rsp_carry, rsp_ovf, rsp_zero)),
            64'(rsp_pack(v.id, v.y, v.c, v.o, v.z)));
        @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        vecs[0] = '{1'b0, 16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b0};
        vecs[1] = '{1'b1, 16'h8000, 16'h0001, 1'b1, 16'h7FFF, 1'b1, 1'b1, 1'b0};
        vecs[2] = '{1'b1, 16'h0000, 16'h0001, 1'b1, 16'hFFFF, 1'b0, 1'b0, 1'b0};
        vecs[3] = '{1'b1, 16'h1234, 16'h1234, 1'b1, 16'h0000, 1'b1, 1'b0, 1'b1};
        vecs[4] = '{1'b0, 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1};
        vecs[5] = '{1'b0, 16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 1'b0, 1'b0};
        vecs[6] = '{1'b1, 16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b1};
        vecs[7] = '{1'b0, 16'h0005, 16'h0007, 1'b1, 16'hFFFE, 1'b0, 1'b0, 1'b0};

        rst = 1'b1; req_valid = 2'b00; rsp_ready = 1'b1;
        a0 = '0; b0 = '0; sub0 = 1'b0; a1 = '0; b1 = '0; sub1 = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // Reset state held while idle
        for (int i = 0; i < 10; i++) begin
            #1;
            chk("idle_state",
                64'({req_ready, rsp_valid, rsp_id, rsp_data, rsp_carry, rsp_ovf, rsp_zero}),
                64'h0);
            @(negedge clk);
        end

        for (int i = 0; i < 8; i++) run_op(vecs[i], $sformatf("vec%0d", i));

        // Contention from a fresh reset: grants 0,1,0,1 every 3 cycles
        do_reset();
        a0 = 16'h0001; b0 = 16'h0001; sub0 = 1'b0;
        a1 = 16'h0010; b1 = 16'h0003; sub1 = 1'b1;
        req_valid = 2'b11;
        for (int c = 0; c < 12; c++) begin
            logic [1:0] er;
            logic       eid;
            #1;
            eid = 1'((c / 3) % 2);
            er  = (c % 3 == 0) ? (eid ? 2'b10 : 2'b01) : 2'b00;
            chk($sformatf("rr_cyc%0d", c), 64'({req_ready, rsp_valid}),
                64'({er, (c % 3 == 2)}));
            if (c % 3 == 2)
                chk($sformatf("rr_rsp%0d", c),
                    64'(rsp_pack(rsp_id, rsp_data, rsp_carry, rsp_ovf, rsp_zero)),
                    eid ? 64'(rsp_pack(1'b1, 16'h000D, 1'b1, 1'b0, 1'b0))
                        : 64'(rsp_pack(1'b0, 16'h0002, 1'b0, 1'b0, 1'b0)));
            if (c == 11) req_valid = 2'b00;
            @(negedge clk);
        end

        // Backpressure: hold RESP for 5 cycles while requester 1 waits
        rsp_ready = 1'b0;
        a0 = 16'h0005; b0 = 16'h0007; sub0 = 1'b1;
        req_valid = 2'b01;
        #1;
        chk("bp_grant0", 64'(req_ready), 64'h1);
        @(negedge clk);
        a1 = 16'h8000; b1 = 16'h8000; sub1 = 1'b0;
        req_valid = 2'b10;
        #1;
        chk("bp_exec", 64'({req_ready, rsp_valid}), 64'h0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk); #1;
            chk($sformatf("bp_hold%0d", i),
                64'({req_ready, rsp_valid, rsp_pack(rsp_id, rsp_data, rsp_carry, rsp_ovf, rsp_zero)}),
                64'({2'b00, 1'b1, rsp_pack(1'b0, 16'hFFFE, 1'b0, 1'b0, 1'b0)}));
        end
        @(negedge clk);
        rsp_ready = 1'b1;
        #1;
        chk("bp_release", 64'({rsp_valid, rsp_data}), 64'({1'b1, 16'hFFFE}));
        @(negedge clk); #1;
        chk("bp_grant1", 64'({req_ready, rsp_valid}), 64'({2'b10, 1'b0}));
        @(negedge clk);
        req_valid = 2'b00;
        @(negedge clk); #1;
        chk("bp_rsp1", 64'({rsp_valid, rsp_pack(rsp_id, rsp_data, rsp_carry, rsp_ovf, rsp_zero)}),
            64'({1'b1, rsp_pack(1'b1, 16'h0000, 1'b1, 1'b1, 1'b1)}));
        @(negedge clk);

        // Leave priority with requester 1, then abandon an op with reset in EXEC
        run_op(vecs[5], "pre_rst");
        a1 = 16'h0001; b1 = 16'h0001; sub1 = 1'b1;
        req_valid = 2'b10;
        #1;
        chk("mid_grant", 64'(req_ready), 64'h2);
        @(negedge clk);
        req_valid = 2'b00;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk($sformatf("mid_quiet%0d", i),
                64'({req_ready, rsp_valid, rsp_id, rsp_data, rsp_carry, rsp_ovf, rsp_zero}),
                64'h0);
            @(negedge clk);
        end
        a0 = 16'hFFFF; b0 = 16'h0001; sub0 = 1'b0;
        req_valid = 2'b11;
        #1;
        chk("post_rst_grant", 64'(req_ready), 64'h1);
        @(negedge clk);
        req_valid = 2'b00;
        @(negedge clk); #1;
        chk("post_rst_rsp", 64'({rsp_valid, rsp_pack(rsp_id, rsp_data, rsp_carry, rsp_ovf, rsp_zero)}),
            64'({1'b1, rsp_pack(1'b0, 16'h0000, 1'b1, 1'b0, 1'b1)}));
        @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule : tb_addsub16_arbiter
`default_nettype wire
